// File: rtl/debug_scanner_pkg.sv
// Shared types and default widths for the debug-port scanner.
package debug_scanner_pkg;

  localparam int unsigned DEF_ADDR_W = 7;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_STEP = 3'd1,
    ST_GAP  = 3'd2,
    ST_ADDR = 3'd3,
    ST_WAIT = 3'd4,
    ST_EMIT = 3'd5,
    ST_FIN  = 3'd6
  } state_e;

  // Number of bits needed to count 0 .. lat-1 (at least one bit).
  function automatic int unsigned lat_width(input int unsigned lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/dbg_step_gen.sv
// Single-step pulse generator: owns the remaining-step down-counter and the
// registered debug_step pulse; the main FSM sequences STEP/GAP around it.
module dbg_step_gen
  import debug_scanner_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_count_i,
  input  logic             dec_i,
  input  logic             step_next_i,
  output logic             debug_step_o,
  output logic             steps_done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q;

  always_comb begin
    cnt_d = cnt_q;
    if (abort_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_count_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // The pulse is registered from the FSM's next state, so it is high exactly
  // during STEP cycles without a decode after the flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step_next_i;
    end
  end

  assign debug_step_o = step_q;
  assign steps_done_o = (cnt_q == '0);

endmodule

// File: rtl/debug_scanner.sv
// Debug-port initiator: freezes the core, issues single steps, then sweeps an
// address range and streams each captured word out over valid/ready.
module debug_scanner
  import debug_scanner_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  step_count,
  input  logic [ADDR_W-1:0] scan_first,
  input  logic [ADDR_W-1:0] scan_last,
  output logic              busy,
  output logic              done,
  output logic              debug_en,
  output logic              debug_step,
  output logic [ADDR_W-1:0] debug_addr,
  input  logic [DATA_W-1:0] debug_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  // Output stream: a word transfers on a cycle where out_valid && out_ready.
  // Once raised, out_valid/out_addr/out_data hold until that transfer (or
  // abort/reset); out_ready only affects state at the next edge.

  localparam int unsigned LAT_W = lat_width(READ_LAT);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] debug_addr_q, debug_addr_d;
  logic              busy_q, done_q, debug_en_q;
  logic              load_steps;
  logic              steps_done;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    last_d       = last_q;
    lat_d        = lat_q;
    out_valid_d  = out_valid_q;
    out_addr_d   = out_addr_q;
    out_data_d   = out_data_q;
    debug_addr_d = debug_addr_q;
    load_steps   = 1'b0;

    if (abort) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_d     = scan_first;
            last_d     = scan_last;
            load_steps = 1'b1;
            state_d    = (step_count != '0) ? ST_STEP : ST_ADDR;
          end
        end
        ST_STEP: state_d = ST_GAP;
        ST_GAP:  state_d = steps_done ? ST_ADDR : ST_STEP;
        ST_ADDR: begin
          lat_d   = '0;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_q == LAT_LAST) begin
            out_data_d  = debug_data;
            out_addr_d  = addr_q;
            out_valid_d = 1'b1;
            state_d     = ST_EMIT;
          end else begin
            lat_d = lat_q + LAT_W'(1);
          end
        end
        ST_EMIT: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            if (addr_q == last_q) begin
              state_d = ST_FIN;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = ST_ADDR;
            end
          end
        end
        ST_FIN:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    // The address is presented as ADDR begins, so the READ_LAT count starts
    // on the first ADDR cycle.
    if (state_d == ST_ADDR) begin
      debug_addr_d = addr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      last_q       <= '0;
      lat_q        <= '0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      debug_addr_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      debug_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      last_q       <= last_d;
      lat_q        <= lat_d;
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      debug_addr_q <= debug_addr_d;
      busy_q       <= (state_d != ST_IDLE);
      done_q       <= (state_d == ST_FIN);
      debug_en_q   <= (state_d != ST_IDLE);
    end
  end

  dbg_step_gen #(
    .CNT_W(CNT_W)
  ) u_step_gen (
    .clk          (clk),
    .rst          (rst),
    .abort_i      (abort),
    .load_i       (load_steps),
    .load_count_i (step_count),
    .dec_i        (state_q == ST_STEP),
    .step_next_i  (state_d == ST_STEP),
    .debug_step_o (debug_step),
    .steps_done_o (steps_done)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign debug_en   = debug_en_q;
  assign debug_addr = debug_addr_q;
  assign out_valid  = out_valid_q;
  assign out_addr   = out_addr_q;
  assign out_data   = out_data_q;

endmodule
